camera_reset_master: RTL and testbench
======================================

CAMERA_RESET_MASTER -- requirements
Module: camera_reset_master

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, number of cycles the camera reset stays asserted (low) between the two writes; legal range 1..65535.
REQ-002 Parameter SETTLE_CYCLES, default 100, number of cycles waited after the release write before the read-back; legal range 1..65535.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum number of waitrequest-stalled cycles tolerated per bus transfer; legal range 1..65535.
REQ-004 Parameter PIO_ADDR, default 2'd0, slave word address of the reset output register.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to run one reset sequence.
REQ-008 busy  output  1  high while a sequence is in progress.
REQ-009 done  output  1  one-cycle pulse when a sequence completes successfully.
REQ-010 error  output  1  sticky flag: timeout or read-back mismatch; cleared by the next accepted start.
REQ-011 avm_address  output  2  Avalon-MM word address.
REQ-012 avm_chipselect  output  1  transfer request.
REQ-013 avm_write_n  output  1  active-low write qualifier (high = read).
REQ-014 avm_writedata  output  1  write data.
REQ-015 avm_readdata  input  1  read data; sampled only on a read's completing cycle.
REQ-016 avm_waitrequest  input  1  slave stall; tie low for a zero-wait slave.

Function
REQ-017 The FSM SHALL have states IDLE, WR_ASSERT, HOLD, WR_RELEASE, SETTLE, RD_CHECK, DONE, with ERR folded into the return to IDLE.
REQ-018 In IDLE, start=1 SHALL move to WR_ASSERT on the next edge and clear error; start while busy SHALL be ignored.
REQ-019 In WR_ASSERT: chipselect=1, write_n=0, address=PIO_ADDR, writedata=0; the transfer completes on the first cycle with waitrequest=0, then go to HOLD.
REQ-020 HOLD SHALL last exactly HOLD_CYCLES cycles using a 16-bit down-counter loaded on entry; the bus SHALL stay idle (chipselect=0).
REQ-021 In WR_RELEASE: chipselect=1, write_n=0, writedata=1; on completion go to SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles with the bus idle.
REQ-023 In RD_CHECK: chipselect=1, write_n=1; on completion sample avm_readdata, then enter DONE if it equals 1, else set error and return to IDLE.
REQ-024 DONE SHALL assert done for one cycle and return to IDLE.
REQ-025 With zero wait states, a start in cycle 0 SHALL produce done in cycle HOLD_CYCLES+SETTLE_CYCLES+4.
REQ-026 Bus outputs SHALL be registered and held stable while waitrequest=1.
REQ-027 Each bus state SHALL count stalled cycles; reaching TIMEOUT_CYCLES SHALL drop chipselect, set error and return to IDLE, with no done pulse.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 When idle, avm_write_n=1, avm_chipselect=0, avm_writedata=0 and avm_address=PIO_ADDR.

Reset
REQ-030 Asserting reset, including mid-sequence, SHALL immediately force IDLE, counters=0, busy=0, done=0, error=0, chipselect=0, write_n=1, writedata=0, address=PIO_ADDR.
REQ-031 The first start SHALL be honoured on the first clock edge after reset deasserts.

Structure
REQ-032 The FSM state encoding and the 16-bit counter width SHALL live in a shared package, camera_ctrl_pkg.
REQ-033 The timeout logic SHALL be one sub-module, avm_timeout_counter (inputs: clear, stall; output: expired).

Verification
REQ-034 Zero-wait slave model, HOLD=4, SETTLE=2, start at cycle 0 -> write 0, 4 idle cycles, write 1, 2 idle cycles, read returns 1, done at cycle 10, error=0.
REQ-035 waitrequest held high 3 cycles on each transfer -> outputs stable during stalls; done delayed by 9 cycles versus REQ-034.
REQ-036 Slave read returns 0 -> error=1, no done, busy=0 after RD_CHECK; next start clears error.
REQ-037 TIMEOUT=5 with waitrequest stuck high in WR_ASSERT -> chipselect drops after 5 stalled cycles, error=1, return to IDLE.
REQ-038 Reset asserted during HOLD -> all outputs take their reset values asynchronously, with no done pulse.
REQ-039 start pulsed during HOLD -> ignored; exactly one done for the sequence.

Source files
------------

// File: rtl/camera_ctrl_pkg.sv
// Shared types for the camera reset controller: FSM encoding and counter width.
package camera_ctrl_pkg;

  localparam int unsigned CntWidth = 16;

  typedef logic [CntWidth-1:0] cnt_t;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWrAssert  = 3'd1,
    StHold      = 3'd2,
    StWrRelease = 3'd3,
    StSettle    = 3'd4,
    StRdCheck   = 3'd5,
    StDone      = 3'd6
  } state_e;

  // Down-counters run from cycles-1 to 0, so a phase lasts exactly `cycles` cycles.
  function automatic cnt_t load_val(int unsigned cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/avm_timeout_counter.sv
// Counts waitrequest-stalled cycles of one bus transfer; expired flags the final tolerated stall.
module avm_timeout_counter
  import camera_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam cnt_t Limit = load_val(TIMEOUT_CYCLES);

  cnt_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (stall && (count_q != Limit)) begin
      count_d = count_q + cnt_t'(1);
    end
  end

  assign expired = stall && !clear && (count_q == Limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/camera_reset_master.sv
// Drives a camera reset PIO over Avalon-MM: assert, hold, release, settle, then read back.
module camera_reset_master
  import camera_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 1000,
  parameter int unsigned SETTLE_CYCLES  = 100,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [1:0]  PIO_ADDR       = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] avm_address,
  output logic       avm_chipselect,
  output logic       avm_write_n,
  output logic       avm_writedata,
  input  logic       avm_readdata,
  input  logic       avm_waitrequest
);

  localparam cnt_t HoldLoad   = load_val(HOLD_CYCLES);
  localparam cnt_t SettleLoad = load_val(SETTLE_CYCLES);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   cs_q, cs_d;
  logic   wn_q, wn_d;
  logic   wd_q, wd_d;

  logic tmo_clear, tmo_stall, tmo_expired;

  assign tmo_clear = !cs_q;
  assign tmo_stall = cs_q && avm_waitrequest;

  avm_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .stall  (tmo_stall),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cs_d    = cs_q;
    wn_d    = wn_q;
    wd_d    = wd_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrAssert;
          err_d   = 1'b0;
          cs_d    = 1'b1;
          wn_d    = 1'b0;
          wd_d    = 1'b0;
        end
      end
      StWrAssert: begin
        if (tmo_expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
          cs_d    = 1'b0;
          wn_d    = 1'b1;
          wd_d    = 1'b0;
        end else if (!avm_waitrequest) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
          cs_d    = 1'b0;
          wn_d    = 1'b1;
          wd_d    = 1'b0;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StWrRelease;
          cs_d    = 1'b1;
          wn_d    = 1'b0;
          wd_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StWrRelease: begin
        if (tmo_expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
          cs_d    = 1'b0;
          wn_d    = 1'b1;
          wd_d    = 1'b0;
        end else if (!avm_waitrequest) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
          cs_d    = 1'b0;
          wn_d    = 1'b1;
          wd_d    = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StRdCheck;
          cs_d    = 1'b1;
          wn_d    = 1'b1;
          wd_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StRdCheck: begin
        if (tmo_expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
          cs_d    = 1'b0;
        end else if (!avm_waitrequest) begin
          cs_d = 1'b0;
          if (avm_readdata) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        wd_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign avm_address    = PIO_ADDR;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wd_q;

endmodule

// File: tb/tb_camera_reset_master.sv
// Scoreboard bench for camera_reset_master: expected bus/done/end events are queued by the
// stimulus and popped by a monitor that watches the DUT outputs on the falling edge.
module tb_camera_reset_master;

  localparam int unsigned Hold   = 4;
  localparam int unsigned Settle = 2;
  localparam int unsigned Tmo    = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [1:0] avm_address;
  logic       avm_chipselect, avm_write_n, avm_writedata;
  logic       avm_readdata = 1'b1;
  logic       avm_waitrequest = 1'b0;

  always #5 clk = ~clk;

  camera_reset_master #(
    .HOLD_CYCLES   (Hold),
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Tmo),
    .PIO_ADDR      (2'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  typedef enum int {EvWrite, EvRead, EvDone, EvAbort, EvEnd} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       data;
    int       rel;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  t0      = 0;

  // Slave model knobs
  int   stall_cfg = 0;
  bit   stuck     = 1'b0;
  logic rd_val    = 1'b1;
  bit   in_xfer   = 1'b0;
  int   left      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_e kind, input int data, input int rel);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic push_normal(input int stalls);
    push(EvWrite, 0, 1 + stalls);
    push(EvWrite, 1, int'(Hold) + 2 + 2 * stalls);
    push(EvRead, 0, int'(Hold + Settle) + 3 + 3 * stalls);
    push(EvDone, 0, int'(Hold + Settle) + 4 + 3 * stalls);
    push(EvEnd, 0, int'(Hold + Settle) + 5 + 3 * stalls);
  endtask

  task automatic observe(input ev_kind_e kind, input int data, input int rel);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got %s rel %0d, expected none", kind.name(), rel);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event_kind(%s)", e.kind.name()), kind, e.kind);
      if (kind == e.kind) begin
        chk($sformatf("%s_data", kind.name()), data, e.data);
        if (e.rel >= 0) chk($sformatf("%s_cycle", kind.name()), rel, e.rel);
      end
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Slave: holds waitrequest for stall_cfg cycles per transfer, or forever while stuck.
  always @(posedge clk) begin
    #1;
    if (avm_chipselect) begin
      if (!in_xfer) begin
        in_xfer = 1'b1;
        left    = stall_cfg;
      end else if (left > 0) begin
        left--;
      end
      avm_waitrequest = stuck || (left > 0);
    end else begin
      in_xfer         = 1'b0;
      avm_waitrequest = 1'b0;
    end
    avm_readdata = rd_val;
  end

  // Monitor
  logic       prev_busy  = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_bus   = '0;
  int         stalls     = 0;

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (prev_stall) begin
      if (avm_chipselect) begin
        chk("stall_stable", {avm_chipselect, avm_write_n, avm_writedata, avm_address[0]},
            prev_bus);
      end else begin
        observe(EvAbort, stalls, rel);
      end
    end
    if (avm_chipselect && !avm_waitrequest) begin
      chk("bus_address", avm_address, 2'd0);
      if (avm_write_n) observe(EvRead, 0, rel);
      else             observe(EvWrite, avm_writedata, rel);
    end
    if (done) observe(EvDone, 0, rel);
    if (prev_busy && !busy) observe(EvEnd, error, rel);
    if (avm_chipselect && avm_waitrequest) stalls++;
    else                                   stalls = 0;
    prev_stall = avm_chipselect && avm_waitrequest;
    prev_bus   = {avm_chipselect, avm_write_n, avm_writedata, avm_address[0]};
    prev_busy  = busy;
  end

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) break;
    end
    repeat (3) @(posedge clk);
    chk({"pending_events_", tag}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_cs"}, avm_chipselect, 1'b0);
    chk({tag, "_write_n"}, avm_write_n, 1'b1);
    chk({tag, "_writedata"}, avm_writedata, 1'b0);
    chk({tag, "_address"}, avm_address, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait sequence
    push_normal(0);
    pulse_start();
    drain("zero_wait", 60);

    // Three stall cycles on every transfer
    stall_cfg = 3;
    push_normal(3);
    pulse_start();
    drain("stall3", 80);
    stall_cfg = 0;

    // Read-back of 0 flags an error, then the next start clears it
    rd_val = 1'b0;
    push(EvWrite, 0, 1);
    push(EvWrite, 1, int'(Hold) + 2);
    push(EvRead, 0, int'(Hold + Settle) + 3);
    push(EvEnd, 1, int'(Hold + Settle) + 4);
    pulse_start();
    drain("readback0", 60);
    chk("error_sticky", error, 1'b1);
    rd_val = 1'b1;
    push_normal(0);
    pulse_start();
    chk("error_cleared_by_start", error, 1'b0);
    drain("after_error", 60);

    // Start pulsed during HOLD is ignored
    push_normal(0);
    pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("start_in_hold", 60);

    // Waitrequest stuck high in WR_ASSERT
    stuck = 1'b1;
    push(EvAbort, int'(Tmo), int'(Tmo) + 1);
    push(EvEnd, 1, int'(Tmo) + 1);
    pulse_start();
    drain("timeout", 60);
    stuck = 1'b0;
    chk("timeout_cs_low", avm_chipselect, 1'b0);
    chk("timeout_error", error, 1'b1);

    // Reset during HOLD, then a start on the first edge after release
    push(EvWrite, 0, 1);
    push(EvEnd, 0, -1);
    pulse_start();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    chk("pending_after_reset", exp_q.size(), 0);
    exp_q.delete();
    push_normal(0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("first_start_after_reset", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
